// File: rtl/sync_fifo_flags_pkg.sv
// Shared widths, mode encodings and op decode
// for the flagged synchronous FIFO.
package sync_fifo_flags_pkg;

  typedef enum int {
    FWFT_OFF = 0,
    FWFT_ON  = 1
  } fwft_mode_e;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WR,
    OP_RD,
    OP_WR_RD
  } fifo_op_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic fifo_op_e op_of(input logic wr, input logic rd);
    fifo_op_e op;
    op = OP_IDLE;
    unique case (1'b1)
      (wr & rd):   op = OP_WR_RD;
      (wr & ~rd):  op = OP_WR;
      (~wr & rd):  op = OP_RD;
      default:     op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle of the flagged FIFO.
// master drives requests, slave is the FIFO.
interface sync_fifo_flags_if
  import sync_fifo_flags_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] data_in;
  logic             wr_en;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             Full;
  logic             Empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, wr_en, rd_en, clr_err,
    input  data_out, Full, Empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  data_in, wr_en, rd_en, clr_err,
    output data_out, Full, Empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags_mem.sv
// FIFO storage: sync write port, async read port.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // store accepted write words
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with any depth, occupancy
// flags, sticky errors and optional FWFT output.
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 10,
  parameter int AF_LEVEL = 8,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic             clk,
  input  logic             reset,
  sync_fifo_flags_if.slave bus
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [WIDTH-1:0]  mem_rdata;
  logic              empty, full;
  logic              rd_ok, wr_ok;
  fifo_op_e          op;

  function automatic logic [ADDR_W-1:0] ptr_inc(
    input logic [ADDR_W-1:0] p
  );
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign rd_ok = bus.rd_en & ~empty;
  assign wr_ok = bus.wr_en & (~full | rd_ok);
  assign op    = op_of(wr_ok, rd_ok);

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // next pointers, occupancy, read register, errors
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      dout_d   = mem_rdata;
    end
    unique case (op)
      OP_WR:   cnt_d = cnt_q + CNT_W'(1);
      OP_RD:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q & ~bus.clr_err;
    unf_d = unf_q & ~bus.clr_err;
    if (bus.wr_en & ~wr_ok) ovf_d = 1'b1;
    if (bus.rd_en & empty)  unf_d = 1'b1;
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.data_out     = (FWFT == int'(FWFT_ON))
                          ? mem_rdata : dout_q;
  assign bus.Full         = full;
  assign bus.Empty        = empty;
  assign bus.almost_full  = (cnt_q >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty = (cnt_q <= CNT_W'(AE_LEVEL));
  assign bus.count        = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: standard-read FIFO checked
// through a data queue, FWFT FIFO directly.
module tb_sync_fifo_flags;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [7:0] q0 [$];

  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(10)) bus0 ();
  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(10)) bus1 ();

  sync_fifo_flags #(
    .WIDTH(8), .DEPTH(10), .AF_LEVEL(8),
    .AE_LEVEL(2), .FWFT(0)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  sync_fifo_flags #(
    .WIDTH(8), .DEPTH(10), .AF_LEVEL(8),
    .AE_LEVEL(2), .FWFT(1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               n, act, exp);
    end
  endtask

  // one cycle on dut0; push expected word after the edge
  task automatic step0(input logic w, input logic [7:0] d,
                       input logic r, input logic c,
                       input logic push);
    bus0.wr_en   = w;
    bus0.data_in = d;
    bus0.rd_en   = r;
    bus0.clr_err = c;
    @(posedge clk);
    #1;
    if (push) q0.push_back(d);
    bus0.wr_en   = 1'b0;
    bus0.rd_en   = 1'b0;
    bus0.clr_err = 1'b0;
  endtask

  task automatic step1(input logic w, input logic [7:0] d,
                       input logic r);
    bus1.wr_en   = w;
    bus1.data_in = d;
    bus1.rd_en   = r;
    @(posedge clk);
    #1;
    bus1.wr_en = 1'b0;
    bus1.rd_en = 1'b0;
  endtask

  // monitor: a read issued while data is expected
  // must present the queue head one edge later
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (reset && bus0.rd_en && q0.size() > 0) begin
        e = q0.pop_front();
        #1;
        chk("rd_data", {24'd0, bus0.data_out}, {24'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
    bus0.clr_err = 1'b0; bus0.data_in = '0;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0;
    bus1.clr_err = 1'b0; bus1.data_in = '0;

    #3;
    chk("rst_empty", 32'(bus0.Empty), 1);
    chk("rst_full", 32'(bus0.Full), 0);
    chk("rst_count", 32'(bus0.count), 0);
    chk("rst_dout", 32'(bus0.data_out), 0);
    chk("rst_ae", 32'(bus0.almost_empty), 1);
    chk("rst_af", 32'(bus0.almost_full), 0);
    chk("rst_ovf", 32'(bus0.overflow), 0);
    chk("rst_unf", 32'(bus0.underflow), 0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 1; i <= 10; i++) begin
      step0(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      chk("fill_count", 32'(bus0.count), 32'(i));
      chk("fill_af", 32'(bus0.almost_full), 32'(i >= 8));
      chk("fill_full", 32'(bus0.Full), 32'(i == 10));
    end
    step0(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(bus0.overflow), 1);
    chk("ovf_count", 32'(bus0.count), 10);

    for (int i = 1; i <= 10; i++) begin
      step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_count", 32'(bus0.count), 32'(10 - i));
      chk("drain_ae", 32'(bus0.almost_empty),
          32'((10 - i) <= 2));
    end
    chk("drain_empty", 32'(bus0.Empty), 1);
    step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("unf_set", 32'(bus0.underflow), 1);
    chk("unf_hold", 32'(bus0.data_out), 32'h1A);
    step0(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", 32'(bus0.overflow), 0);
    chk("clr_unf", 32'(bus0.underflow), 0);

    for (int i = 1; i <= 7; i++)
      step0(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++)
      step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++)
      step0(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b1);
    chk("wrap_count", 32'(bus0.count), 7);
    for (int i = 1; i <= 7; i++)
      step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_empty", 32'(bus0.Empty), 1);

    for (int i = 1; i <= 10; i++)
      step0(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    step0(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    chk("fullrw_count", 32'(bus0.count), 10);
    chk("fullrw_ovf", 32'(bus0.overflow), 0);
    chk("fullrw_full", 32'(bus0.Full), 1);
    for (int i = 1; i <= 10; i++)
      step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fullrw_empty", 32'(bus0.Empty), 1);
    step0(1'b1, 8'h66, 1'b1, 1'b0, 1'b1);
    chk("emptyrw_count", 32'(bus0.count), 1);
    chk("emptyrw_unf", 32'(bus0.underflow), 1);
    step0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step0(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("unf_prio", 32'(bus0.underflow), 1);
    step0(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("unf_clr", 32'(bus0.underflow), 0);
    chk("sb_drained", 32'(q0.size()), 0);

    step1(1'b1, 8'h5A, 1'b0);
    chk("fwft_dout", 32'(bus1.data_out), 32'h5A);
    chk("fwft_empty", 32'(bus1.Empty), 0);
    for (int i = 1; i <= 4; i++)
      step1(1'b1, 8'(8'h5A + i), 1'b0);
    chk("fwft_count5", 32'(bus1.count), 5);
    chk("fwft_head", 32'(bus1.data_out), 32'h5A);
    step1(1'b0, 8'h00, 1'b1);
    chk("fwft_pop", 32'(bus1.data_out), 32'h5B);
    chk("fwft_count4", 32'(bus1.count), 4);
    step1(1'b1, 8'h5F, 1'b0);
    chk("fwft_count5b", 32'(bus1.count), 5);
    bus1.wr_en   = 1'b1;
    bus1.data_in = 8'h77;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(bus1.Empty), 1);
    chk("mid_rst_count", 32'(bus1.count), 0);
    chk("mid_rst_count0", 32'(bus0.count), 0);
    @(posedge clk);
    #1;
    bus1.wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_count", 32'(bus1.count), 0);
    chk("post_rst_empty", 32'(bus1.Empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
